uart_rx_packer: RTL and testbench

UART_RX_PACKER -- requirements
Module: uart_rx_packer

---
 rtl/uart_rx_packer.sv | 135 +++++++++++++
 tb/tb_uart_rx_packer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_packer.sv
// Packs received UART bytes into BYTES-wide FIFO words, LSB-first, with an idle-timeout
// flush of partial words and sticky drop/word statistics.
module uart_rx_packer #(
  parameter int unsigned BYTES   = 4,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       rx_valid,
  input  logic [7:0]                 rx_data,
  input  logic                       fifo_full,
  input  logic                       i_clr_ovf,
  output logic                       o_wren_fifo,
  output logic [BYTES*8-1:0]         o_rx_data,
  output logic [$clog2(BYTES+1)-1:0] o_valid_bytes,
  output logic                       o_overflow,
  output logic [CNT_W-1:0]           o_drop_cnt,
  output logic [CNT_W-1:0]           o_word_cnt,
  output logic                       o_busy
);

  localparam int unsigned IdxW  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int unsigned IdleW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned VbW   = $clog2(BYTES + 1);

  localparam logic [IdxW-1:0]  IdxLast  = IdxW'(BYTES - 1);
  localparam logic [IdleW-1:0] IdleLast = (TIMEOUT > 0) ? IdleW'(TIMEOUT - 1) : '0;
  localparam bit               FlushEn  = (TIMEOUT > 0);

  typedef enum logic {StAccum, StWrite} state_e;

  state_e             state_q, state_d;
  logic [IdxW-1:0]    idx_q, idx_d;
  logic [IdleW-1:0]   idle_q, idle_d;
  logic [BYTES*8-1:0] lanes_q, lanes_d;
  logic [VbW-1:0]     vb_q, vb_d;
  logic               overflow_q, overflow_d;
  logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic               drop;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    idle_d      = idle_q;
    lanes_d     = lanes_q;
    vb_d        = vb_q;
    o_wren_fifo = 1'b0;
    unique case (state_q)
      StAccum: begin
        if (rx_valid) begin
          lanes_d[8*idx_q +: 8] = rx_data;
          idle_d                = '0;
          if (idx_q == IdxLast) begin
            state_d = StWrite;
            vb_d    = VbW'(BYTES);
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else if (idx_q == '0) begin
          idle_d = '0;
        end else if (FlushEn) begin
          if (idle_q == IdleLast) begin
            // Partial flush: lanes beyond idx were cleared after the previous write
            state_d = StWrite;
            vb_d    = VbW'(idx_q);
            idx_d   = '0;
            idle_d  = '0;
          end else begin
            idle_d = idle_q + 1'b1;
          end
        end
      end
      StWrite: begin
        idle_d = '0;
        if (!fifo_full) begin
          o_wren_fifo = 1'b1;
          state_d     = StAccum;
          lanes_d     = '0;
          vb_d        = '0;
        end
      end
      default: state_d = StAccum;
    endcase
  end

  // Any byte arriving while a word is pending is lost, including on the write cycle
  assign drop = (state_q == StWrite) && rx_valid;

  always_comb begin
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    word_cnt_d = word_cnt_q;
    if (i_clr_ovf) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 1'b1;
    end
    if (o_wren_fifo) word_cnt_d = word_cnt_q + 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= StAccum;
      idx_q      <= '0;
      idle_q     <= '0;
      lanes_q    <= '0;
      vb_q       <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      idle_q     <= idle_d;
      lanes_q    <= lanes_d;
      vb_q       <= vb_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  assign o_rx_data     = lanes_q;
  assign o_valid_bytes = vb_q;
  assign o_overflow    = overflow_q;
  assign o_drop_cnt    = drop_cnt_q;
  assign o_word_cnt    = word_cnt_q;
  assign o_busy        = (state_q != StAccum) || (idx_q != '0);

endmodule

// File: tb/tb_uart_rx_packer.sv
// Directed bench for uart_rx_packer: a BYTES=4/TIMEOUT=16 instance plus a BYTES=1,
// CNT_W=4 instance that makes counter wrap and saturation reachable in few cycles.
module tb_uart_rx_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        rx_valid, fifo_full, clr_ovf;
  logic [7:0]  rx_data;
  logic        wren, ovf, busy;
  logic [31:0] data;
  logic [2:0]  vb;
  logic [15:0] drop_cnt, word_cnt;

  logic       s_valid, s_full, s_clr;
  logic [7:0] s_data;
  logic       s_wren, s_ovf, s_busy;
  logic [7:0] s_rx;
  logic [0:0] s_vb;
  logic [3:0] s_drop, s_word;

  uart_rx_packer #(.BYTES(4), .TIMEOUT(16), .CNT_W(16)) dut (
    .i_clk(clk), .i_rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .fifo_full(fifo_full), .i_clr_ovf(clr_ovf), .o_wren_fifo(wren), .o_rx_data(data),
    .o_valid_bytes(vb), .o_overflow(ovf), .o_drop_cnt(drop_cnt), .o_word_cnt(word_cnt),
    .o_busy(busy)
  );

  uart_rx_packer #(.BYTES(1), .TIMEOUT(0), .CNT_W(4)) dut_small (
    .i_clk(clk), .i_rst(rst), .rx_valid(s_valid), .rx_data(s_data),
    .fifo_full(s_full), .i_clr_ovf(s_clr), .o_wren_fifo(s_wren), .o_rx_data(s_rx),
    .o_valid_bytes(s_vb), .o_overflow(s_ovf), .o_drop_cnt(s_drop), .o_word_cnt(s_word),
    .o_busy(s_busy)
  );

  int n_chk = 0;
  int n_pass = 0;
  int wr_cnt = 0;
  int base;

  // Count main-instance FIFO writes mid-cycle, away from the active edge
  always @(negedge clk) if (wren) wr_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = '0; fifo_full = 1'b0; clr_ovf = 1'b0;
    s_valid = 1'b0; s_data = '0; s_full = 1'b0; s_clr = 1'b0;
    repeat (3) tick();
    check("rst_wren", {31'b0, wren}, 32'h0);
    check("rst_vb", {29'b0, vb}, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_ovf", {31'b0, ovf}, 32'h0);
    check("rst_drop", {16'b0, drop_cnt}, 32'h0);
    check("rst_word", {16'b0, word_cnt}, 32'h0);
    check("rst_data", data, 32'h0);
    rst = 1'b0;
    tick();

    // Full word on consecutive cycles: write one cycle after the last byte
    base = wr_cnt;
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    #1;
    check("full_wren", {31'b0, wren}, 32'h1);
    check("full_data", data, 32'h4433_2211);
    check("full_vb", {29'b0, vb}, 32'h4);
    tick();
    check("full_wr_cnt", wr_cnt, base + 1);
    check("full_word_cnt", {16'b0, word_cnt}, 32'h1);
    check("full_idle_busy", {31'b0, busy}, 32'h0);

    // Timeout: idle counter hits 15 on the 16th idle cycle, write the cycle after
    base = wr_cnt;
    send(8'hAA); send(8'hBB);
    repeat (15) tick();
    check("to_early_wren", {31'b0, wren}, 32'h0);
    check("to_early_cnt", wr_cnt, base);
    tick();
    check("to_wren", {31'b0, wren}, 32'h1);
    check("to_data", data, 32'h0000_BBAA);
    check("to_vb", {29'b0, vb}, 32'h2);
    tick();
    check("to_wr_cnt", wr_cnt, base + 1);
    check("to_word_cnt", {16'b0, word_cnt}, 32'h2);

    // Byte on the 16th idle cycle cancels the flush
    base = wr_cnt;
    send(8'hAA); send(8'hBB);
    repeat (15) tick();
    send(8'hCC);
    check("nto_wren", {31'b0, wren}, 32'h0);
    check("nto_busy", {31'b0, busy}, 32'h1);
    send(8'hDD);
    check("nto_data", data, 32'hDDCC_BBAA);
    check("nto_wren_full", {31'b0, wren}, 32'h1);
    tick();
    check("nto_wr_cnt", wr_cnt, base + 1);

    // Back-pressure for 10 cycles with 3 bytes arriving during the stall
    base = wr_cnt;
    fifo_full = 1'b1;
    send(8'h55); send(8'h66); send(8'h77); send(8'h88);
    for (int k = 0; k < 10; k++) begin
      rx_valid = (k % 3 == 1);
      rx_data  = 8'(k);
      #1 check("stall_wren", {31'b0, wren}, 32'h0);
      tick();
    end
    rx_valid = 1'b0;
    check("stall_wr_cnt", wr_cnt, base);
    check("stall_drop", {16'b0, drop_cnt}, 32'h3);
    check("stall_ovf", {31'b0, ovf}, 32'h1);
    fifo_full = 1'b0;
    #1;
    check("stall_rel_wren", {31'b0, wren}, 32'h1);
    check("stall_rel_data", data, 32'h8877_6655);
    tick();
    check("stall_rel_cnt", wr_cnt, base + 1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("clr_ovf", {31'b0, ovf}, 32'h0);
    check("clr_drop", {16'b0, drop_cnt}, 32'h0);

    // Clear coinciding with a drop: clear wins
    fifo_full = 1'b1;
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    rx_valid = 1'b1; clr_ovf = 1'b1;
    tick();
    rx_valid = 1'b0; clr_ovf = 1'b0;
    check("clrwin_ovf", {31'b0, ovf}, 32'h0);
    check("clrwin_drop", {16'b0, drop_cnt}, 32'h0);
    fifo_full = 1'b0;
    tick();
    check("clrwin_word_cnt", {16'b0, word_cnt}, 32'h5);

    // Reset mid-word discards the partial word; next byte lands in lane 0
    base = wr_cnt;
    send(8'hE1); send(8'hE2);
    rst = 1'b1;
    #1;
    check("midrst_busy", {31'b0, busy}, 32'h0);
    check("midrst_word", {16'b0, word_cnt}, 32'h0);
    tick();
    rst = 1'b0;
    tick();
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    #1;
    check("postrst_data", data, 32'h0403_0201);
    check("postrst_wren", {31'b0, wren}, 32'h1);
    tick();
    check("postrst_wr_cnt", wr_cnt, base + 1);
    check("postrst_word", {16'b0, word_cnt}, 32'h1);

    // BYTES=1: every byte is a word; 16 words wrap the 4-bit word counter
    for (int i = 0; i < 16; i++) begin
      s_valid = 1'b1;
      s_data  = 8'(i + 1);
      tick();
      s_valid = 1'b0;
      check("s_wren", {31'b0, s_wren}, 32'h1);
      check("s_data", {24'b0, s_rx}, i + 1);
      tick();
      if (i == 14) check("s_word_max", {28'b0, s_word}, 32'hF);
    end
    check("s_word_wrap", {28'b0, s_word}, 32'h0);

    // 20 drops saturate the 4-bit drop counter
    s_full = 1'b1; s_valid = 1'b1; s_data = 8'hA5;
    tick();
    repeat (20) tick();
    s_valid = 1'b0;
    check("s_drop_sat", {28'b0, s_drop}, 32'hF);
    check("s_ovf", {31'b0, s_ovf}, 32'h1);
    check("s_stall_wren", {31'b0, s_wren}, 32'h0);
    check("s_busy", {31'b0, s_busy}, 32'h1);
    s_full = 1'b0;
    #1;
    check("s_rel_wren", {31'b0, s_wren}, 32'h1);
    check("s_rel_data", {24'b0, s_rx}, 32'hA5);
    check("s_rel_vb", {31'b0, s_vb}, 32'h1);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
